// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light phase monitor:
// phase codes, default durations, monitor states, phase order.
package traffic_pkg;

  localparam logic [1:0] PH_RED     = 2'b00;
  localparam logic [1:0] PH_GREEN   = 2'b01;
  localparam logic [1:0] PH_YELLOW  = 2'b10;
  localparam logic [1:0] PH_ILLEGAL = 2'b11;

  localparam int DEF_RED_TICKS    = 18;
  localparam int DEF_GREEN_TICKS  = 15;
  localparam int DEF_YELLOW_TICKS = 3;

  typedef enum logic [1:0] {
    ST_UNSYNC,
    ST_RED,
    ST_GREEN,
    ST_YELLOW
  } mon_state_e;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_RED:    next_phase = PH_GREEN;
      PH_GREEN:  next_phase = PH_YELLOW;
      PH_YELLOW: next_phase = PH_RED;
      default:   next_phase = PH_ILLEGAL;
    endcase
  endfunction

  function automatic mon_state_e phase_state(input logic [1:0] ph);
    case (ph)
      PH_RED:    phase_state = ST_RED;
      PH_GREEN:  phase_state = ST_GREEN;
      PH_YELLOW: phase_state = ST_YELLOW;
      default:   phase_state = ST_UNSYNC;
    endcase
  endfunction

endpackage

// File: rtl/traffic_sat_counter.sv
// 8-bit saturating violation counter with synchronous clear.
// A clear coinciding with an event leaves the count at one.
module traffic_sat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= {7'd0, inc};
    end else if (inc && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/traffic_led_monitor.sv
// Traffic light phase monitor: lamp drive, phase timing and order checks.
// Optional violation counter enabled by TRAFFIC_MON_COUNTERS_EN.
module traffic_led_monitor
  import traffic_pkg::*;
#(
  parameter int RED_TICKS    = DEF_RED_TICKS,
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       led,
  input  logic             err_clr,
  output logic             lamp_r,
  output logic             lamp_g,
  output logic             lamp_y,
  output logic             synced,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             err_code,
  output logic             err_seq,
  output logic             err_dur,
  output logic [7:0]       err_count
);

  mon_state_e       state;
  mon_state_e       state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] ticks;
  logic [1:0]       cur;
  logic [1:0]       nxt;
  logic [1:0]       prev;
  logic             prev_vld;
  logic             is_ill;
  logic             in_ph;
  logic             set_code;
  logic             set_seq;
  logic             set_dur;

  assign is_ill = (led == PH_ILLEGAL);
  assign in_ph  = (state != ST_UNSYNC);
  assign synced = in_ph;
  assign nxt    = next_phase(cur);

  always_comb begin
    cur   = PH_RED;
    ticks = CNT_W'(RED_TICKS);
    case (state)
      ST_GREEN: begin
        cur   = PH_GREEN;
        ticks = CNT_W'(GREEN_TICKS);
      end
      ST_YELLOW: begin
        cur   = PH_YELLOW;
        ticks = CNT_W'(YELLOW_TICKS);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state;
    cnt_d    = phase_cnt;
    set_code = 1'b0;
    set_seq  = 1'b0;
    set_dur  = 1'b0;
    unique case (1'b1)
      is_ill: begin
        state_d  = ST_UNSYNC;
        cnt_d    = '0;
        set_code = 1'b1;
      end
      !is_ill && !in_ph: begin
        // first legal change after reset/11 marks a phase boundary
        if (prev_vld && led != prev) begin
          state_d = phase_state(led);
          cnt_d   = CNT_W'(1);
        end
      end
      in_ph && led == cur: begin
        if (phase_cnt != '1) cnt_d = phase_cnt + CNT_W'(1);
        set_dur = (phase_cnt == ticks);
      end
      in_ph && led == nxt: begin
        set_dur = (phase_cnt != ticks);
        state_d = phase_state(led);
        cnt_d   = CNT_W'(1);
      end
      default: begin
        set_seq = 1'b1;
        state_d = phase_state(led);
        cnt_d   = CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_UNSYNC;
      phase_cnt <= '0;
      prev      <= PH_RED;
      prev_vld  <= 1'b0;
      lamp_r    <= 1'b0;
      lamp_g    <= 1'b0;
      lamp_y    <= 1'b0;
      err_code  <= 1'b0;
      err_seq   <= 1'b0;
      err_dur   <= 1'b0;
    end else begin
      state     <= state_d;
      phase_cnt <= cnt_d;
      prev      <= led;
      prev_vld  <= 1'b1;
      lamp_r    <= (led == PH_RED);
      lamp_g    <= (led == PH_GREEN);
      lamp_y    <= (led == PH_YELLOW);
      err_code  <= (err_code & ~err_clr) | set_code;
      err_seq   <= (err_seq & ~err_clr) | set_seq;
      err_dur   <= (err_dur & ~err_clr) | set_dur;
    end
  end

`ifdef TRAFFIC_MON_COUNTERS_EN
  logic viol;
  assign viol = set_code | set_seq | set_dur;

  traffic_sat_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (err_clr),
    .inc   (viol),
    .count (err_count)
  );
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: doc/traffic_led_monitor.md
# traffic_led_monitor

Receive-side checker for the 2-bit traffic-light phase code (00 Red, 01 Green, 10 Yellow) driven by the traffic FSM. The block samples the code every clock and drives one-hot lamp outputs. It measures how long each phase lasts and flags illegal codes, out-of-order transitions and wrong phase durations. It sits between the controller and the lamp drivers/bench scoreboard, and is also used as a bound-in protocol monitor.

## Interface
- RED_TICKS, 18: required Red phase length in clk cycles
- GREEN_TICKS, 15: required Green phase length
- YELLOW_TICKS, 3: required Yellow phase length
- CNT_W, 5: phase counter width; must hold max(*_TICKS)+1
- clk  input  1  sampling clock, rising edge
- rst_n  input  1  asynchronous, active-high reset
- led  input  2  phase code under observation
- err_clr  input  1  synchronous clear of sticky error flags
- lamp_r / lamp_g / lamp_y  output  1 each  registered one-hot lamp drive
- synced  output  1  monitor has seen a phase boundary and is checking
- phase_cnt  output  CNT_W  cycles spent in current phase, 1-based
- err_code  output  1  sticky: code 11 seen
- err_seq  output  1  sticky: illegal successor seen
- err_dur  output  1  sticky: phase too short or too long
- err_count  output  8  saturating violation count (see Configuration)

## Operation
- States: UNSYNC, RED, GREEN, YELLOW. Reset enters UNSYNC.
- Legal order: RED→GREEN→YELLOW→RED.
- UNSYNC:
  - Latch led into prev each cycle.
  - On the first change of led to a legal code, enter that phase with phase_cnt=1 and assert synced.
  - The first partial phase after reset is never duration-checked.
- In a phase, led equal to the current code: phase_cnt increments, saturating at all-ones.
  - When phase_cnt would exceed that phase's *_TICKS, set err_dur once (overrun).
- In a phase, led changes to the legal successor:
  - If phase_cnt != the current phase's *_TICKS, set err_dur.
  - Enter the successor with phase_cnt=1.
- In a phase, led changes to a non-successor legal code: set err_seq and enter the new code's phase with phase_cnt=1. Synced stays 1.
- led == 11 in any state:
  - Set err_code, go to UNSYNC, deassert synced, drive all lamps 0.
  - Every sample of 11 is a violation event.
- Lamps:
  - lamp_r = (led==00), lamp_g = (led==01), lamp_y = (led==10), registered.
  - All zero in UNSYNC until the first legal code is sampled.
- Error flags are sticky until err_clr. If err_clr and a new violation occur in the same cycle, the flag ends set.
- A single sample raising several flags (e.g. err_seq plus err_dur is impossible; err_code alone) counts as one violation event.

## Timing
- All outputs are registered. lamp_*, phase_cnt, state and error flags reflect the led sampled at edge N after edge N (one-cycle latency).
- Reset values: lamp_r=lamp_g=lamp_y=0, synced=0, phase_cnt=0, err_code=err_seq=err_dur=0, err_count=0, state UNSYNC.
- Reset mid-phase discards all history. The next phase is again unchecked.
- The boundary check happens on the cycle the new code is first sampled. phase_cnt then reads 1 at the following edge.

## Configuration
- TRAFFIC_MON_COUNTERS_EN defined:
  - err_count increments by 1 per violation event and saturates at 255.
  - err_clr also zeroes it.
- Undefined: counter logic is not built and err_count is tied to 0. The port remains for a stable interface.

## Structure
- Shared package traffic_pkg holds:
  - phase code constants PH_RED=2'b00, PH_GREEN=2'b01, PH_YELLOW=2'b10, PH_ILLEGAL=2'b11
  - default durations 18/15/3
  - the monitor state encoding
  - next-phase function
- One sub-module is natural: traffic_sat_counter (8-bit saturating event counter with sync clear), instantiated only under TRAFFIC_MON_COUNTERS_EN.

## Test plan
- Reset release, then led held 00 for 10 cycles, then 01 → synced=1 on the cycle after 01 is sampled; no errors; lamp_g=1.
- Synced, then clean cycle Green 15, Yellow 3, Red 18, Green 15 → all error flags stay 0; phase_cnt peaks at 15/3/18.
- Synced, Green held 16 cycles → err_dur set at the 16th Green sample; err_count=1.
- Synced, Red then 10 (skip Green) → err_seq=1, state YELLOW, phase_cnt=1.
- led=11 for 2 cycles while Green → err_code=1, synced=0, lamps 0, err_count=2; then assert err_clr → flags and count are 0 the next cycle.
- err_clr asserted on the same cycle a Yellow phase ends at count 2 → err_dur remains 1; assert rst_n mid-Red → all outputs return to reset values.
